// File: rtl/btn_pkg.sv
// btn_pkg: shared state type and sizing helper for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        B_IDLE,
        B_PRESS_WAIT,
        B_HELD,
        B_RELEASE_WAIT
    } btn_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus press/release debounce FSM for one button
// With BTN_AUTOREPEAT_EN defined an extra in_held_o port reports the B_HELD state.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic held_o,
    output logic press_evt_o
`ifdef BTN_AUTOREPEAT_EN
    ,
    output logic in_held_o
`endif
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic REL = (BTN_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          pressed;
    btn_state_t    state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held_q, evt_q;

    assign pressed = sync_q[1] ^ REL;
    assign cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
    assign held_o      = held_q;
    assign press_evt_o = evt_q;
`ifdef BTN_AUTOREPEAT_EN
    assign in_held_o = (state_q == B_HELD);
`endif

    // Two-stage synchronizer, reset to the released level
    always_ff @(posedge clk) begin
        sync_q <= rst ? {2{REL}} : {sync_q[0], raw_i};
    end

    // Debounce FSM: a level is accepted after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (state_q)
                B_IDLE: begin
                    if (pressed) begin
                        state_q <= B_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                B_PRESS_WAIT: begin
                    if (!pressed) begin
                        state_q <= B_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= B_HELD;
                        held_q  <= 1'b1;
                        evt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                B_HELD: begin
                    if (!pressed) begin
                        state_q <= B_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                B_RELEASE_WAIT: begin
                    if (pressed) begin
                        state_q <= B_HELD;
                    end else if (cnt_q == LAST) begin
                        state_q <= B_IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced move/select buttons turned into arbitrated one-cycle pulses
// Optional feature: define BTN_AUTOREPEAT_EN for move auto-repeat while held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic move_raw,
    input  logic select_raw,
    input  logic enable,
    output logic move_pulse,
    output logic select_pulse,
    output logic move_held,
    output logic select_held
);

    logic move_evt, sel_evt, move_any;
    logic move_pulse_q, select_pulse_q, pend_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RCW = cnt_width(REPEAT_DELAY);
    logic           move_in_held, sel_in_held, rep_evt;
    logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_move (
        .clk        (clk),
        .rst        (rst),
        .raw_i      (move_raw),
        .held_o     (move_held),
        .press_evt_o(move_evt)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .in_held_o  (move_in_held)
`endif
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_select (
        .clk        (clk),
        .rst        (rst),
        .raw_i      (select_raw),
        .held_o     (select_held),
        .press_evt_o(sel_evt)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .in_held_o  (sel_in_held)
`endif
    );

`ifdef BTN_AUTOREPEAT_EN
    // Counter reloads so it hits REPEAT_DELAY again every REPEAT_PERIOD cycles
    assign rep_evt   = move_in_held && (rep_cnt_q == RCW'(REPEAT_DELAY));
    assign rep_cnt_d = !move_in_held ? '0 :
                       rep_evt ? RCW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rep_cnt_q + 1'b1;
    assign move_any  = move_evt | rep_evt;

    // Repeat counter runs only while the move FSM sits in B_HELD
    always_ff @(posedge clk) begin
        rep_cnt_q <= rst ? '0 : rep_cnt_d;
    end
`else
    assign move_any = move_evt;
`endif

    assign move_pulse   = move_pulse_q;
    assign select_pulse = select_pulse_q;

    // Select wins a tie; a colliding move event waits one slot in the pending flag
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            move_pulse_q   <= 1'b0;
            select_pulse_q <= 1'b0;
            pend_q         <= 1'b0;
        end else if (sel_evt) begin
            select_pulse_q <= 1'b1;
            move_pulse_q   <= 1'b0;
            pend_q         <= pend_q | move_any;
        end else begin
            select_pulse_q <= 1'b0;
            move_pulse_q   <= pend_q | move_any;
            pend_q         <= 1'b0;
        end
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream stage of the board-cursor/turn logic. Converts the raw, bouncing move and select push-buttons into clean single-cycle pulses in the clk domain.
- Its move_pulse and select_pulse outputs drive the cursor-advance and card-select inputs of the game board controller. This replaces raw button edges used as clocks.
- One instance per board. Two identical per-button debouncers, plus output arbitration.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 means a raw input at 0 is "pressed" (DE-board KEY); 0 means active-high.
- REPEAT_DELAY, 25000000, held cycles before the first auto-repeat move pulse (used only with the optional feature).
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat move pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- move_raw  input  1  raw move button, asynchronous
- select_raw  input  1  raw select button, asynchronous
- enable  input  1  0 suppresses all output pulses (game finished or locked)
- move_pulse  output  1  one-cycle pulse: advance cursor
- select_pulse  output  1  one-cycle pulse: select current card
- move_held  output  1  debounced move level (1 = pressed)
- select_held  output  1  debounced select level (1 = pressed)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All flops update on posedge clk only.
- Reset values:
  - move_pulse = select_pulse = 0.
  - move_held = select_held = 0.
  - Synchronizer flops hold the "released" level.
  - Debounce counters = 0; FSMs in B_IDLE; pending flag = 0.
- Synchronizer: each raw input passes through 2 flops, then is normalised to pressed = 1 using BTN_ACTIVE_LOW.
- Per-button FSM:
  - B_IDLE: sync = 1 → B_PRESS_WAIT, counter cleared.
  - B_PRESS_WAIT: counter increments each cycle while sync = 1. sync = 0 → B_IDLE, counter cleared. Counter reaching DEBOUNCE_CYCLES-1 with sync = 1 → B_HELD; held goes to 1 and a press event is raised for that cycle.
  - B_HELD: sync = 0 → B_RELEASE_WAIT, counter cleared.
  - B_RELEASE_WAIT: counter increments while sync = 0. sync = 1 → B_HELD. Counter reaching DEBOUNCE_CYCLES-1 → B_IDLE, held = 0. A release raises no event.
- Latency: a clean raw press produces the press event, and held = 1, exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples the pressed level. Pulses are registered and appear one cycle after the event.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps. DEBOUNCE_CYCLES = 1 is legal: a level is accepted after a single stable cycle.
- Arbitration:
  - Select events have priority.
  - If select and move events occur in the same cycle, select_pulse fires and the move event is stored in the pending flag. move_pulse fires on the next cycle without a select event.
  - Pending depth is 1. A new move event arriving while pending is already set is dropped.
  - move_pulse and select_pulse are never high together.
- enable = 0: events are discarded (not queued) and pending is cleared. FSMs and held outputs keep running, so a button already held when enable rises produces no pulse.
- Reset mid-press: the FSM returns to B_IDLE. A button still held after rst deasserts is re-debounced and produces a pulse.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - While the move FSM stays in B_HELD, a repeat counter raises an extra move event REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles.
  - The repeat counter is cleared on leaving B_HELD and on rst.
  - Repeat events follow the same arbitration and enable rules as press events.
  - select never auto-repeats.
- Undefined: no repeat counter exists; exactly one move_pulse per debounced press.

Decomposition:
- Package btn_pkg:
  - typedef enum logic [1:0] btn_state_t {B_IDLE, B_PRESS_WAIT, B_HELD, B_RELEASE_WAIT}.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module btn_debounce (synchronizer + FSM + counter; outputs held and press_evt). It is instantiated twice.
- Arbitration, pending flag, enable gating and the optional repeat logic live in btn_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: drive move_raw 1→0 and hold 10 cycles → exactly one move_pulse, 7 cycles after the first sampling edge. move_held = 1 from 6 cycles after that edge. select_pulse stays 0.
- Bounce: toggle select_raw 0/1 every 2 cycles for 12 cycles, then hold 0 → no pulse during the bouncing. One select_pulse once 0 has been stable for 4 synchronized cycles. Release with bounce → no pulse.
- Simultaneous: press both buttons on the same cycle → select_pulse at cycle T, move_pulse at T+1, never both high.
- Enable gating: hold enable = 0 and press move; raise enable while move is still held → no move_pulse. Release and press again with enable = 1 → one pulse.
- Reset mid-operation: assert rst for 1 cycle while in B_PRESS_WAIT (count 2) → all outputs 0. Keep the button held → pulse 6 cycles after the cycle rst is sampled low, plus the 1-cycle output register.
- With BTN_AUTOREPEAT_EN: hold move 60 cycles → first pulse, then repeats at +20, +28, +36, +44, +52 cycles after held rose. Without the macro → a single pulse.
